// File: rtl/ftdi_fifo_rx_adapter.sv
// ftdi_fifo_rx_adapter: reads bytes from an FTDI async FIFO (FRXF/FRD) into a local FIFO write port.
// Define FTDI_RX_COUNT_EN to add the 32-bit rx_count output counting written bytes.
module ftdi_fifo_rx_adapter #(
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 3,
    parameter int FIFO_LIMIT  = 2040
) (
    input  logic        wrclk,
    input  logic        rst,
    input  logic        FRXF,
    output logic        FRD,
    input  logic [7:0]  FDATA,
    input  logic [10:0] usedw,
    input  logic        rx_en,
    output logic        wrreq,
    output logic [7:0]  data,
    output logic        rx_busy
`ifdef FTDI_RX_COUNT_EN
    ,
    output logic [31:0] rx_count
`endif
);
    typedef enum logic [1:0] {IDLE, STROBE, WRITE, RECOVER} state_t;

    state_t     state, next;
    logic [3:0] cnt, cnt_nx;
    logic       rxf_m, rxf_s;

    always_ff @(posedge wrclk) begin
        if (rst) begin
            rxf_m <= 1'b1;
            rxf_s <= 1'b1;
        end else begin
            rxf_m <= FRXF;
            rxf_s <= rxf_m;
        end
    end

    // cnt reloads on every state entry and counts down to zero, so it never wraps
    always_comb begin
        next   = state;
        cnt_nx = cnt;
        case (state)
            IDLE:
                if (rx_en && !rxf_s && 32'(usedw) < FIFO_LIMIT) begin
                    next   = STROBE;
                    cnt_nx = 4'(RD_LOW_CYC - 1);
                end
            STROBE:
                if (cnt == 4'd0) next = WRITE;
                else cnt_nx = cnt - 4'd1;
            WRITE: begin
                next   = RECOVER;
                cnt_nx = 4'(RD_HIGH_CYC - 2);
            end
            RECOVER:
                if (cnt == 4'd0) next = IDLE;
                else cnt_nx = cnt - 4'd1;
            default: begin
                next   = IDLE;
                cnt_nx = 4'd0;
            end
        endcase
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            FRD   <= 1'b1;
            wrreq <= 1'b0;
            data  <= 8'h00;
        end else begin
            state <= next;
            cnt   <= cnt_nx;
            FRD   <= next != STROBE;
            wrreq <= next == WRITE;
            if (state == STROBE && next == WRITE) data <= FDATA;
        end
    end

    assign rx_busy = state != IDLE;

`ifdef FTDI_RX_COUNT_EN
    always_ff @(posedge wrclk) begin
        if (rst) rx_count <= 32'd0;
        else if (wrreq) rx_count <= rx_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ftdi_fifo_rx_adapter.sv
// tb_ftdi_fifo_rx_adapter: directed self-checking bench for ftdi_fifo_rx_adapter.
module tb_ftdi_fifo_rx_adapter;
    logic        wrclk = 1'b0;
    logic        rst = 1'b1;
    logic        FRXF = 1'b1;
    logic        FRD;
    logic [7:0]  FDATA = 8'h00;
    logic [10:0] usedw = 11'd0;
    logic        rx_en = 1'b1;
    logic        wrreq;
    logic [7:0]  data;
    logic        rx_busy;
`ifdef FTDI_RX_COUNT_EN
    logic [31:0] rx_count;
`endif
    int total = 0;
    int bad = 0;

    ftdi_fifo_rx_adapter dut (
        .wrclk(wrclk), .rst(rst), .FRXF(FRXF), .FRD(FRD), .FDATA(FDATA),
        .usedw(usedw), .rx_en(rx_en), .wrreq(wrreq), .data(data), .rx_busy(rx_busy)
`ifdef FTDI_RX_COUNT_EN
        , .rx_count(rx_count)
`endif
    );

    always #5 wrclk = ~wrclk;

    task automatic step;
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        FRXF = 1'b1;
        rx_en = 1'b1;
        usedw = 11'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // FTDI model: byte k sits on FDATA until FRD rises; FRXF goes high once n bytes are consumed
    task automatic run_ftdi(input int n, input int cycles, output int pulses, output int errs, output int late_low);
        int idx = 0;
        logic prev;
        pulses = 0;
        errs = 0;
        late_low = 0;
        FDATA = 8'h00;
        FRXF = (n == 0);
        prev = FRD;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (wrreq) begin
                if (data !== 8'(pulses)) errs++;
                pulses++;
            end
            if (!prev && FRD) begin
                idx++;
                FDATA = 8'(idx);
                FRXF = idx >= n;
            end else if (idx >= n && !FRD) late_low++;
            prev = FRD;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        total++; if (FRD !== 1'b1) begin bad++; $display("FAIL reset_frd got=%b exp=1", FRD); end
        total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq got=%b exp=0", wrreq); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic exp_frd, exp_wr;
        do_reset();
        FDATA = 8'hA5;
        FRXF = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_frd = !(k >= 3 && k <= 6);
            exp_wr = (k == 7);
            total++; if (FRD !== exp_frd) begin bad++; $display("FAIL single_frd k=%0d got=%b exp=%b", k, FRD, exp_frd); end
            total++; if (wrreq !== exp_wr) begin bad++; $display("FAIL single_wrreq k=%0d got=%b exp=%b", k, wrreq, exp_wr); end
            if (k == 7) begin
                total++; if (data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", data); end
            end
            if (k == 4) begin
                total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", rx_busy); end
            end
        end
        step();
        total++; if (FRD !== 1'b0) begin bad++; $display("FAIL single_next_read got=%b exp=0", FRD); end
    endtask

    task automatic test_stream;
        int p, e, l;
        do_reset();
        run_ftdi(10, 150, p, e, l);
        total++; if (p != 10) begin bad++; $display("FAIL stream_count got=%0d exp=10", p); end
        total++; if (e != 0) begin bad++; $display("FAIL stream_data_order got=%0d bad bytes exp=0", e); end
        total++; if (l != 0) begin bad++; $display("FAIL stream_frd_after got=%0d low cycles exp=0", l); end
    endtask

    task automatic test_full;
        int lows = 0;
        int lat = 0;
        do_reset();
        usedw = 11'd2040;
        FDATA = 8'h11;
        FRXF = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!FRD) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL full_blocked got=%0d low cycles exp=0", lows); end
        usedw = 11'd2039;
        while (FRD && lat < 4) begin
            step();
            lat++;
        end
        total++; if (lat > 2 || FRD) begin bad++; $display("FAIL full_resume got=%0d cycles exp<=2", lat); end
    endtask

    task automatic test_rx_en_drop;
        int wc = 0;
        int lat = 0;
        int post = 0;
        do_reset();
        FDATA = 8'h3C;
        FRXF = 1'b0;
        while (FRD && lat < 10) begin
            step();
            lat++;
        end
        step();
        rx_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (wrreq) begin
                wc++;
                total++; if (data !== 8'h3C) begin bad++; $display("FAIL rxen_data got=%h exp=3c", data); end
            end
            if (wc > 0 && !FRD) post++;
        end
        total++; if (wc != 1) begin bad++; $display("FAIL rxen_writes got=%0d exp=1", wc); end
        total++; if (post != 0) begin bad++; $display("FAIL rxen_no_more_reads got=%0d exp=0", post); end
    endtask

    task automatic test_rst_mid;
        int wc = 0;
        int lat = 0;
        do_reset();
        FDATA = 8'h5A;
        FRXF = 1'b0;
        while (FRD && lat < 10) begin
            step();
            lat++;
        end
        step();
        step();
        total++; if (FRD !== 1'b0) begin bad++; $display("FAIL rstmid_strobe got=%b exp=0", FRD); end
        rst = 1'b1;
        step();
        total++; if (FRD !== 1'b1) begin bad++; $display("FAIL rstmid_frd got=%b exp=1", FRD); end
        rst = 1'b0;
        FRXF = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (wrreq) wc++;
        end
        total++; if (wc != 0) begin bad++; $display("FAIL rstmid_wrreq got=%0d exp=0", wc); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", data); end
    endtask

`ifdef FTDI_RX_COUNT_EN
    task automatic test_count;
        int p, e, l;
        do_reset();
        run_ftdi(5, 80, p, e, l);
        total++; if (rx_count !== 32'd5) begin bad++; $display("FAIL count_five got=%0d exp=5", rx_count); end
        force dut.rx_count = 32'hFFFFFFFF;
        step();
        release dut.rx_count;
        run_ftdi(1, 30, p, e, l);
        total++; if (rx_count !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h exp=0", rx_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_rx_en_drop();
        test_rst_mid();
`ifdef FTDI_RX_COUNT_EN
        test_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
